// File: rtl/pwl_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwl_eval_ctrl
//  Purpose  : Sequencer and configuration owner for a 5-segment piecewise-
//             linear evaluator.  Holds breakpoints x1..x4 and slope/intercept
//             pairs (m1..m5, c1..c5) and streams signed samples through a
//             3-stage pipeline: region select -> multiply -> shift/add/sat.
//  Ports    :
//    clk, rst_n            clock, asynchronous active-low reset
//    en                    level run request; deassert to drain and stop
//    cfg_we/addr/wdata     configuration write port (accepted in IDLE only)
//    cfg_err               one-cycle pulse on rejected write or start
//    in_valid/ready/data   sample input handshake
//    out_valid/ready       result output handshake
//    out_data/region/sat   result y = m*x + c, its region 1..5, clamp flag
//    busy                  controller not idle
//    out_count             delivered result counter (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module pwl_eval_ctrl #(
    parameter int W         = 32,
    parameter int FRAC_BITS = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [W-1:0]     cfg_wdata,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [2:0]       out_region,
    output logic             out_sat,
    output logic             busy,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [3:0] ADDR_M_BASE = 4'd4;
    localparam logic [3:0] ADDR_C_BASE = 4'd9;
    localparam logic [3:0] ADDR_RSVD   = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic signed [W-1:0] x_q [4];
    logic signed [W-1:0] m_q [5];
    logic signed [W-1:0] c_q [5];

    logic en_q;
    logic cfg_err_q, cfg_err_d;

    logic w_ordered;
    logic w_cfg_wr;
    logic w_adv;
    logic w_acc;
    logic w_pipe_any;

    // Pipeline registers
    logic                  s1_v_q;
    logic signed [W-1:0]   s1_x_q, s1_m_q, s1_c_q;
    logic [2:0]            s1_r_q;
    logic                  s2_v_q;
    logic signed [2*W-1:0] s2_p_q;
    logic signed [W-1:0]   s2_c_q;
    logic [2:0]            s2_r_q;
    logic                  out_valid_q;
    logic [W-1:0]          out_data_q;
    logic [2:0]            out_region_q;
    logic                  out_sat_q;
    logic [CNT_W-1:0]      out_count_q;

    assign w_ordered = (x_q[0] < x_q[1]) && (x_q[1] < x_q[2]) && (x_q[2] < x_q[3]);
    assign w_cfg_wr  = cfg_we && (state_q == ST_IDLE) && (cfg_addr < ADDR_RSVD);
    assign w_adv     = !out_valid_q || out_ready;
    assign w_acc     = in_valid && in_ready;
    assign w_pipe_any = s1_v_q || s2_v_q || out_valid_q;

    assign in_ready   = w_adv && (state_q == ST_RUN);
    assign busy       = (state_q != ST_IDLE);
    assign cfg_err    = cfg_err_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_region = out_region_q;
    assign out_sat    = out_sat_q;
    assign out_count  = out_count_q;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en && w_ordered) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = ST_DRAIN;
            // Config cannot change outside IDLE, so the ordering that was
            // valid on entry to RUN still holds for a re-entry from DRAIN.
            ST_DRAIN: begin
                if (en)               state_d = ST_RUN;
                else if (!w_pipe_any) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_err_d = 1'b0;
        if (cfg_we && ((state_q != ST_IDLE) || (cfg_addr >= ADDR_RSVD)))
            cfg_err_d = 1'b1;
        // Only a rising edge of en reports a bad start, so a held request
        // against bad breakpoints produces a single pulse.
        if ((state_q == ST_IDLE) && en && !en_q && !w_ordered)
            cfg_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) x_q[i] <= '0;
            for (int i = 0; i < 5; i++) begin
                m_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else if (w_cfg_wr) begin
            for (int i = 0; i < 4; i++)
                if (cfg_addr == 4'(i)) x_q[i] <= cfg_wdata;
            for (int i = 0; i < 5; i++) begin
                if (cfg_addr == ADDR_M_BASE + 4'(i)) m_q[i] <= cfg_wdata;
                if (cfg_addr == ADDR_C_BASE + 4'(i)) c_q[i] <= cfg_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: region select (equal-to-breakpoint falls in upper region)
    // ------------------------------------------------------------------
    logic signed [W-1:0] w_x, w_m, w_c;
    logic [2:0]          w_reg;

    assign w_x = $signed(in_data);

    always_comb begin
        w_reg = 3'd1;
        w_m   = m_q[0];
        w_c   = c_q[0];
        if (w_x >= x_q[3]) begin
            w_reg = 3'd5; w_m = m_q[4]; w_c = c_q[4];
        end else if (w_x >= x_q[2]) begin
            w_reg = 3'd4; w_m = m_q[3]; w_c = c_q[3];
        end else if (w_x >= x_q[1]) begin
            w_reg = 3'd3; w_m = m_q[2]; w_c = c_q[2];
        end else if (w_x >= x_q[0]) begin
            w_reg = 3'd2; w_m = m_q[1]; w_c = c_q[1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: full-width signed product
    // ------------------------------------------------------------------
    logic signed [2*W-1:0] w_xe, w_me, w_prod;

    assign w_xe   = {{W{s1_x_q[W-1]}}, s1_x_q};
    assign w_me   = {{W{s1_m_q[W-1]}}, s1_m_q};
    assign w_prod = w_xe * w_me;

    // ------------------------------------------------------------------
    // Stage 3: floor shift, add intercept at 2W+1 bits, clamp to W bits
    // ------------------------------------------------------------------
    logic signed [2*W-1:0] w_shift;
    logic        [2*W:0]   w_sum;
    logic                  w_fits;
    logic        [W-1:0]   w_y;

    assign w_shift = s2_p_q >>> FRAC_BITS;
    assign w_sum   = {w_shift[2*W-1], w_shift} + {{(W+1){s2_c_q[W-1]}}, s2_c_q};
    // Representable in W bits iff all bits above the W-bit sign agree with it.
    assign w_fits  = (&w_sum[2*W:W-1]) || !(|w_sum[2*W:W-1]);
    assign w_y     = w_fits      ? w_sum[W-1:0] :
                     w_sum[2*W]  ? {1'b1, {(W-1){1'b0}}} :
                                   {1'b0, {(W-1){1'b1}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q       <= 1'b0;
            s1_x_q       <= '0;
            s1_m_q       <= '0;
            s1_c_q       <= '0;
            s1_r_q       <= '0;
            s2_v_q       <= 1'b0;
            s2_p_q       <= '0;
            s2_c_q       <= '0;
            s2_r_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_region_q <= '0;
            out_sat_q    <= 1'b0;
        end else if (w_adv) begin
            s1_v_q <= w_acc;
            if (w_acc) begin
                s1_x_q <= w_x;
                s1_m_q <= w_m;
                s1_c_q <= w_c;
                s1_r_q <= w_reg;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_p_q <= w_prod;
                s2_c_q <= s1_c_q;
                s2_r_q <= s1_r_q;
            end
            // Result fields only change when a new result lands, so they
            // hold their last value across bubbles.
            out_valid_q <= s2_v_q;
            if (s2_v_q) begin
                out_data_q   <= w_y;
                out_region_q <= s2_r_q;
                out_sat_q    <= !w_fits;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_count_q <= '0;
        else if (out_valid_q && out_ready)
            out_count_q <= out_count_q + CNT_W'(1);
    end

endmodule
`default_nettype wire

// File: tb/tb_pwl_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwl_eval_ctrl
//  Purpose  : Directed self-checking bench for pwl_eval_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwl_eval_ctrl;

    localparam int W     = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_we;
    logic [3:0]       cfg_addr;
    logic [W-1:0]     cfg_wdata;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [2:0]       out_region;
    logic             out_sat;
    logic             busy;
    logic [CNT_W-1:0] out_count;

    int n_cmp     = 0;
    int n_bad     = 0;
    int exp_count = 0;

    pwl_eval_ctrl #(.W(W), .FRAC_BITS(16), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_err    (cfg_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_region (out_region),
        .out_sat    (out_sat),
        .busy       (busy),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic cfg_write(input logic [3:0] a, input logic [W-1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Feeds one sample with out_ready high; returns the result and the
    // number of cycles from acceptance to out_valid.
    task automatic run_sample(input logic [W-1:0] d, output logic [W-1:0] y,
                              output logic [2:0] r, output logic s,
                              output int lat, output bit to);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        to = !in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        to = to || !out_valid;
        y = out_data; r = out_region; s = out_sat;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
        n_cmp++; if (out_region !== 3'd0) begin n_bad++; $display("FAIL rst_out_region: got %0d expected 0", out_region); end
        n_cmp++; if (out_sat !== 1'b0) begin n_bad++; $display("FAIL rst_out_sat: got %b expected 0", out_sat); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL rst_cfg_err: got %b expected 0", cfg_err); end
        n_cmp++; if (out_count !== 16'd0) begin n_bad++; $display("FAIL rst_out_count: got %0d expected 0", out_count); end
    endtask

    task automatic test_bad_start(input string tag);
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL %s_err_pulse: got %b expected 1", tag, cfg_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy: got %b expected 0", tag, busy); end
        @(negedge clk);
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL %s_err_once: got %b expected 0", tag, cfg_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_stay_idle: got %b expected 0", tag, busy); end
        en = 1'b0;
    endtask

    task automatic test_cfg_write;
        cfg_write(4'd0,  32'hFFFE_0000);   // x1 = -2
        cfg_write(4'd1,  32'hFFFF_0000);   // x2 = -1
        cfg_write(4'd2,  32'h0001_0000);   // x3 =  1
        cfg_write(4'd3,  32'h0002_0000);   // x4 =  2
        cfg_write(4'd4,  32'h0002_0000);   // m1 = 2
        cfg_write(4'd5,  32'h0000_8000);   // m2 = 0.5
        cfg_write(4'd6,  32'h0001_0000);   // m3 = 1
        cfg_write(4'd7,  32'h0000_8000);   // m4 = 0.5
        cfg_write(4'd8,  32'h0002_0000);   // m5 = 2
        cfg_write(4'd12, 32'h0000_8000);   // c4 = 0.5
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_idle_no_err: got %b expected 0", cfg_err); end
        cfg_write(4'd14, 32'h1234_5678);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL cfg_rsvd_err: got %b expected 1", cfg_err); end
        @(negedge clk);
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL cfg_rsvd_err_len: got %b expected 0", cfg_err); end
    endtask

    task automatic test_region3;
        logic [W-1:0] y; logic [2:0] r; logic s; int lat; bit to;
        @(negedge clk); en = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy: got %b expected 1", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL start_in_ready: got %b expected 1", in_ready); end
        run_sample(32'h0000_0000, y, r, s, lat, to); exp_count++;
        n_cmp++; if (to || lat != 3) begin n_bad++; $display("FAIL r3_latency: got %0d (timeout %0d) expected 3", lat, to); end
        n_cmp++; if (y !== 32'h0) begin n_bad++; $display("FAIL r3_data: got %h expected 00000000", y); end
        n_cmp++; if (r !== 3'd3) begin n_bad++; $display("FAIL r3_region: got %0d expected 3", r); end
        n_cmp++; if (s !== 1'b0) begin n_bad++; $display("FAIL r3_sat: got %b expected 0", s); end
    endtask

    task automatic test_slope_intercept;
        logic [W-1:0] y; logic [2:0] r; logic s; int lat; bit to;
        run_sample(32'h0001_8000, y, r, s, lat, to); exp_count++;
        n_cmp++; if (to || y !== 32'h0001_4000 || r !== 3'd4 || s !== 1'b0) begin n_bad++;
            $display("FAIL r4_mid: got y=%h r=%0d s=%b expected y=00014000 r=4 s=0", y, r, s); end
        run_sample(32'h0001_0000, y, r, s, lat, to); exp_count++;
        n_cmp++; if (to || y !== 32'h0001_0000 || r !== 3'd4) begin n_bad++;
            $display("FAIL r4_on_bp: got y=%h r=%0d expected y=00010000 r=4", y, r); end
        // -98303 * 0.5 = -49151.5, floors to -49152
        run_sample(32'hFFFE_8001, y, r, s, lat, to); exp_count++;
        n_cmp++; if (to || y !== 32'hFFFF_4000 || r !== 3'd2 || s !== 1'b0) begin n_bad++;
            $display("FAIL r2_floor: got y=%h r=%0d s=%b expected y=ffff4000 r=2 s=0", y, r, s); end
    endtask

    task automatic test_saturation;
        logic [W-1:0] y; logic [2:0] r; logic s; int lat; bit to;
        run_sample(32'h7FFF_FFFF, y, r, s, lat, to); exp_count++;
        n_cmp++; if (to || y !== 32'h7FFF_FFFF || r !== 3'd5 || s !== 1'b1) begin n_bad++;
            $display("FAIL sat_pos: got y=%h r=%0d s=%b expected y=7fffffff r=5 s=1", y, r, s); end
        run_sample(32'h8000_0000, y, r, s, lat, to); exp_count++;
        n_cmp++; if (to || y !== 32'h8000_0000 || r !== 3'd1 || s !== 1'b1) begin n_bad++;
            $display("FAIL sat_neg: got y=%h r=%0d s=%b expected y=80000000 r=1 s=1", y, r, s); end
    endtask

    task automatic test_cfg_in_run;
        logic [W-1:0] y; logic [2:0] r; logic s; int lat; bit to;
        cfg_write(4'd6, 32'h0002_0000);
        n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL run_cfg_err: got %b expected 1", cfg_err); end
        @(negedge clk);
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL run_cfg_err_len: got %b expected 0", cfg_err); end
        run_sample(32'h0000_8000, y, r, s, lat, to); exp_count++;
        n_cmp++; if (to || y !== 32'h0000_8000 || r !== 3'd3) begin n_bad++;
            $display("FAIL run_cfg_unchanged: got y=%h r=%0d expected y=00008000 r=3", y, r); end
        @(negedge clk);
        n_cmp++; if (out_count !== CNT_W'(exp_count)) begin n_bad++;
            $display("FAIL count_after_single: got %0d expected %0d", out_count, exp_count); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] smp [8];
        int tx = 0, rx = 0, cyc = 0, stalls = 0;
        for (int i = 0; i < 8; i++) smp[i] = 32'(i * 4096 + 16);
        while (rx < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (tx < 8);
            if (tx < 8) in_data = smp[tx];
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_in_ready: cycle %0d got %b expected 0", cyc, in_ready); end
            end
            if (in_valid && in_ready) tx++;
            if (out_valid && out_ready) begin
                n_cmp++; if (out_data !== smp[rx] || out_region !== 3'd3) begin n_bad++;
                    $display("FAIL b2b_order: idx %0d got %h r=%0d expected %h r=3", rx, out_data, out_region, smp[rx]); end
                rx++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        exp_count += 8;
        n_cmp++; if (rx != 8) begin n_bad++; $display("FAIL b2b_received: got %0d expected 8", rx); end
        n_cmp++; if (stalls != 3) begin n_bad++; $display("FAIL b2b_stall_cycles: got %0d expected 3", stalls); end
        n_cmp++; if (out_count !== CNT_W'(exp_count)) begin n_bad++;
            $display("FAIL b2b_count: got %0d expected %0d", out_count, exp_count); end
    endtask

    task automatic test_drain;
        logic [W-1:0] d [3];
        int rx = 0, cyc = 0;
        d[0] = 32'h0000_0100; d[1] = 32'h0000_0200; d[2] = 32'hFFFF_FF00;
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_data = d[0];
        @(negedge clk); in_data = d[1];
        @(negedge clk); in_data = d[2]; en = 1'b0;
        @(negedge clk); in_data = 32'h0000_7777;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy: got %b expected 1", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL drain_in_ready: got %b expected 0", in_ready); end
        while (busy && cyc < 20) begin
            if (out_valid) begin
                if (rx < 3) begin
                    n_cmp++; if (out_data !== d[rx]) begin n_bad++;
                        $display("FAIL drain_data: idx %0d got %h expected %h", rx, out_data, d[rx]); end
                end else begin
                    n_cmp++; n_bad++; $display("FAIL drain_extra: got extra output %h expected none", out_data);
                end
                rx++;
            end
            @(negedge clk); cyc++;
        end
        in_valid = 1'b0;
        exp_count += 3;
        n_cmp++; if (rx != 3) begin n_bad++; $display("FAIL drain_outputs: got %0d expected 3", rx); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drain_idle: got %b expected 0", busy); end
        n_cmp++; if (out_count !== CNT_W'(exp_count)) begin n_bad++;
            $display("FAIL drain_count: got %0d expected %0d", out_count, exp_count); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); en = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_data = 32'h0000_0300; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_streaming: got %b expected 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        exp_count = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_count !== 16'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d expected 0", out_count); end
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_bad++;
            $display("FAIL mid_rst_ctrl: got busy=%b in_ready=%b expected 0 0", busy, in_ready); end
        in_valid = 1'b0; en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        test_bad_start("mid_cfg_cleared");
    endtask

    initial begin
        test_reset;
        test_bad_start("zero_bp");
        test_cfg_write;
        test_region3;
        test_slope_intercept;
        test_saturation;
        test_cfg_in_run;
        test_back_to_back;
        test_drain;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
